// File: rtl/jts16_char_fetch.sv
// Tile-ROM fetch bridge for the character layer: 2-entry tag cache in front of
// an SDRAM cs/ok slot, with a watchdog that re-issues requests the SDRAM drops.
module jts16_char_fetch #(
   parameter int AW      = 13,
   parameter int DW      = 32,
   parameter int TIMEOUT = 63
)(
   input  logic          rst,
   input  logic          clk,
   input  logic          flush,
   input  logic [AW-1:0] lyr_addr,
   output logic          lyr_ok,
   output logic [DW-1:0] lyr_data,
   output logic          rom_cs,
   output logic [AW-1:0] rom_addr,
   input  logic          rom_ok,
   input  logic [DW-1:0] rom_data,
   output logic [7:0]    retries
);

   typedef enum logic [1:0] { IDLE, ARM, WAIT, RETRY } state_t;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hff) ? v : v + 8'd1;
   endfunction

   state_t        state;
   logic [AW-1:0] addr_l, last_addr;
   logic          last_vld, ok_r, lru;
   logic [7:0]    cnt;
   logic [1:0]    valid;
   logic [AW-1:0] tag  [2];
   logic [DW-1:0] data [2];

   logic hit0, hit1, hit, hit_sel, need_eval, addr_chg, fill;

   always_comb begin
      hit0      = valid[0] && (tag[0] == addr_l);
      hit1      = valid[1] && (tag[1] == addr_l);
      hit       = hit0 || hit1;
      hit_sel   = hit1;
      // last_vld is cleared by reset and flush so the current address is looked up again
      need_eval = !last_vld || (addr_l != last_addr);
      addr_chg  = addr_l != rom_addr;
      fill      = (state == WAIT) && !addr_chg && rom_ok && !flush;
   end

   assign lyr_ok = ok_r && (lyr_addr == addr_l);

   always_ff @(posedge clk, posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         addr_l    <= '0;
         last_addr <= '0;
         last_vld  <= 1'b0;
         ok_r      <= 1'b0;
         lru       <= 1'b0;
         cnt       <= 8'd0;
         valid     <= 2'b00;
         rom_cs    <= 1'b0;
         rom_addr  <= '0;
         lyr_data  <= '0;
         retries   <= 8'd0;
      end else begin
         addr_l <= lyr_addr;
         case (state)
            IDLE: begin
               if (!flush && need_eval) begin
                  if (hit) begin
                     lyr_data  <= data[hit_sel];
                     ok_r      <= 1'b1;
                     lru       <= ~hit_sel;
                     last_addr <= addr_l;
                     last_vld  <= 1'b1;
                  end else begin
                     ok_r     <= 1'b0;
                     rom_addr <= addr_l;
                     rom_cs   <= 1'b1;
                     cnt      <= 8'd0;
                     state    <= ARM;
                  end
               end
            end
            // rom_ok may still belong to the previous address here
            ARM: begin
               if (addr_chg) begin
                  rom_addr <= addr_l;
                  cnt      <= 8'd0;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (addr_chg) begin
                  rom_addr <= addr_l;
                  cnt      <= 8'd0;
                  state    <= ARM;
               end else if (rom_ok) begin
                  lyr_data  <= rom_data;
                  ok_r      <= 1'b1;
                  rom_cs    <= 1'b0;
                  last_addr <= rom_addr;
                  last_vld  <= 1'b1;
                  state     <= IDLE;
                  if (fill) begin
                     valid[lru] <= 1'b1;
                     lru        <= ~lru;
                  end
               end else if (cnt == TMO) begin
                  rom_cs  <= 1'b0;
                  retries <= sat_inc(retries);
                  state   <= RETRY;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RETRY: begin
               rom_addr <= addr_l;
               rom_cs   <= 1'b1;
               cnt      <= 8'd0;
               state    <= ARM;
            end
            default: state <= IDLE;
         endcase
         if (flush) begin
            valid    <= 2'b00;
            ok_r     <= 1'b0;
            last_vld <= 1'b0;
         end
         // any pending address change invalidates whatever is presented
         if (lyr_addr != addr_l) ok_r <= 1'b0;
      end
   end

   // cache payload needs no reset: valid bits gate every use
   always_ff @(posedge clk) begin
      if (fill) begin
         tag[lru]  <= rom_addr;
         data[lru] <= rom_data;
      end
   end

endmodule

// File: tb/tb_jts16_char_fetch.sv
// Directed bench for jts16_char_fetch with TIMEOUT=8: cache hits/misses, LRU,
// stale rom_ok, flush, abort, watchdog retry and retry counter saturation.
module tb_jts16_char_fetch;

   localparam int AW = 13;
   localparam int DW = 32;

   logic          rst, clk, flush;
   logic [AW-1:0] lyr_addr;
   logic          lyr_ok;
   logic [DW-1:0] lyr_data;
   logic          rom_cs;
   logic [AW-1:0] rom_addr;
   logic          rom_ok;
   logic [DW-1:0] rom_data;
   logic [7:0]    retries;

   int nvec = 0;
   int nerr = 0;

   jts16_char_fetch #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
      .rst      (rst),
      .clk      (clk),
      .flush    (flush),
      .lyr_addr (lyr_addr),
      .lyr_ok   (lyr_ok),
      .lyr_data (lyr_data),
      .rom_cs   (rom_cs),
      .rom_addr (rom_addr),
      .rom_ok   (rom_ok),
      .rom_data (rom_data),
      .retries  (retries)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Miss from IDLE with rom_ok in the first WAIT cycle: lyr_ok at N+4
   task automatic fetch_miss(input logic [AW-1:0] a, input logic [DW-1:0] d);
      lyr_addr = a;
      #1;
      chk("miss_drop", 64'(lyr_ok), 64'd0);
      tick;
      chk("miss_n1_cs", 64'(rom_cs), 64'd0);
      tick;
      chk("miss_cs", 64'(rom_cs), 64'd1);
      chk("miss_addr", 64'(rom_addr), 64'(a));
      chk("miss_n2_ok", 64'(lyr_ok), 64'd0);
      tick;
      rom_ok   = 1'b1;
      rom_data = d;
      tick;
      rom_ok = 1'b0;
      chk("miss_ok", 64'(lyr_ok), 64'd1);
      chk("miss_data", 64'(lyr_data), 64'(d));
      chk("miss_cs_low", 64'(rom_cs), 64'd0);
   endtask

   task automatic hit(input logic [AW-1:0] a, input logic [DW-1:0] d);
      lyr_addr = a;
      #1;
      chk("hit_drop", 64'(lyr_ok), 64'd0);
      tick;
      chk("hit_n1_cs", 64'(rom_cs), 64'd0);
      tick;
      chk("hit_ok", 64'(lyr_ok), 64'd1);
      chk("hit_data", 64'(lyr_data), 64'(d));
      chk("hit_cs", 64'(rom_cs), 64'd0);
   endtask

   initial begin
      rst      = 1'b1;
      flush    = 1'b0;
      lyr_addr = 13'h0123;
      rom_ok   = 1'b0;
      rom_data = '0;

      // reset values
      repeat (3) tick;
      chk("rst_cs", 64'(rom_cs), 64'd0);
      chk("rst_ok", 64'(lyr_ok), 64'd0);
      chk("rst_retries", 64'(retries), 64'd0);
      chk("rst_data", 64'(lyr_data), 64'd0);
      chk("rst_addr", 64'(rom_addr), 64'd0);

      // first address after reset is requested, then reset hits it in WAIT
      rst = 1'b0;
      tick;
      tick;
      chk("first_cs", 64'(rom_cs), 64'd1);
      chk("first_addr", 64'(rom_addr), 64'h0123);
      tick;
      rst = 1'b1;
      #1;
      chk("midrst_cs", 64'(rom_cs), 64'd0);
      chk("midrst_ok", 64'(lyr_ok), 64'd0);
      chk("midrst_retries", 64'(retries), 64'd0);
      tick;
      rst = 1'b0;

      // miss then hit
      tick;
      tick;
      chk("re_cs", 64'(rom_cs), 64'd1);
      chk("re_addr", 64'(rom_addr), 64'h0123);
      tick;
      rom_ok   = 1'b1;
      rom_data = 32'hDEADBEEF;
      tick;
      rom_ok = 1'b0;
      chk("fill_ok", 64'(lyr_ok), 64'd1);
      chk("fill_data", 64'(lyr_data), 64'hDEADBEEF);
      chk("fill_cs", 64'(rom_cs), 64'd0);
      fetch_miss(13'h0456, 32'h44560000);
      hit(13'h0123, 32'hDEADBEEF);

      // LRU replacement
      fetch_miss(13'h0001, 32'h00010001);
      fetch_miss(13'h0002, 32'h00020002);
      hit(13'h0001, 32'h00010001);
      fetch_miss(13'h0003, 32'h00030003);
      hit(13'h0001, 32'h00010001);
      fetch_miss(13'h0002, 32'h00020022);

      // stale rom_ok held high across an address change
      rom_ok   = 1'b1;
      rom_data = 32'h5A5A0000;
      lyr_addr = 13'h0100;
      tick;
      tick;
      chk("stale_arm_cs", 64'(rom_cs), 64'd1);
      chk("stale_arm_ok", 64'(lyr_ok), 64'd0);
      tick;
      chk("stale_n3_ok", 64'(lyr_ok), 64'd0);
      rom_data = 32'h01000100;
      tick;
      rom_ok = 1'b0;
      chk("stale_ok", 64'(lyr_ok), 64'd1);
      chk("stale_data", 64'(lyr_data), 64'h01000100);

      // flush drops ok and re-requests a cached address
      fetch_miss(13'h0010, 32'h10101010);
      flush = 1'b1;
      #1;
      chk("flush_pre_ok", 64'(lyr_ok), 64'd1);
      tick;
      flush = 1'b0;
      chk("flush_ok", 64'(lyr_ok), 64'd0);
      tick;
      chk("flush_cs", 64'(rom_cs), 64'd1);
      chk("flush_addr", 64'(rom_addr), 64'h0010);
      tick;
      rom_ok   = 1'b1;
      rom_data = 32'h10101011;
      tick;
      rom_ok = 1'b0;
      chk("flush_refill_ok", 64'(lyr_ok), 64'd1);
      chk("flush_refill_data", 64'(lyr_data), 64'h10101011);

      // address change mid-WAIT aborts the old request
      lyr_addr = 13'h0020;
      repeat (4) tick;
      lyr_addr = 13'h0030;
      #1;
      chk("abort_drop", 64'(lyr_ok), 64'd0);
      tick;
      rom_ok   = 1'b1;
      rom_data = 32'hBAD00020;
      chk("abort_cs_held", 64'(rom_cs), 64'd1);
      tick;
      chk("abort_newaddr", 64'(rom_addr), 64'h0030);
      chk("abort_cs_held2", 64'(rom_cs), 64'd1);
      chk("abort_ok_arm", 64'(lyr_ok), 64'd0);
      tick;
      chk("abort_ok_wait", 64'(lyr_ok), 64'd0);
      rom_data = 32'h30303030;
      tick;
      rom_ok = 1'b0;
      chk("abort_ok", 64'(lyr_ok), 64'd1);
      chk("abort_data", 64'(lyr_data), 64'h30303030);
      fetch_miss(13'h0020, 32'h20202020);

      // flush coinciding with rom_ok suppresses the fill
      lyr_addr = 13'h0040;
      repeat (3) tick;
      rom_ok   = 1'b1;
      rom_data = 32'h40404040;
      flush    = 1'b1;
      tick;
      rom_ok = 1'b0;
      flush  = 1'b0;
      chk("flushfill_ok", 64'(lyr_ok), 64'd0);
      tick;
      chk("flushfill_cs", 64'(rom_cs), 64'd1);
      chk("flushfill_addr", 64'(rom_addr), 64'h0040);
      tick;
      rom_ok   = 1'b1;
      rom_data = 32'h40404041;
      tick;
      rom_ok = 1'b0;
      chk("flushfill_ok2", 64'(lyr_ok), 64'd1);
      chk("flushfill_data", 64'(lyr_data), 64'h40404041);

      // watchdog: 1 low cycle of rom_cs every 11 cycles
      lyr_addr = 13'h0050;
      tick;
      tick;
      for (int i = 0; i < 22; i++) begin
         chk("wd_cs", 64'(rom_cs), ((i % 11) == 10) ? 64'd0 : 64'd1);
         if (i == 10) chk("wd_retries1", 64'(retries), 64'd1);
         if (i == 11) chk("wd_addr", 64'(rom_addr), 64'h0050);
         if (i < 21) tick;
      end
      chk("wd_retries2", 64'(retries), 64'd2);
      chk("wd_ok", 64'(lyr_ok), 64'd0);
      repeat (252 * 11) tick;
      chk("wd_retries254", 64'(retries), 64'd254);
      chk("wd_cs254", 64'(rom_cs), 64'd0);
      repeat (11) tick;
      chk("wd_retries255", 64'(retries), 64'd255);
      repeat (50 * 11) tick;
      chk("wd_sat", 64'(retries), 64'd255);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
